// File: rtl/i2c_transaction_sequencer.sv
// Register-level I2C master sequencer: walks the timing/bit engine through
// START, address, register pointer, optional RESTART, data bytes and STOP.
module i2c_transaction_sequencer #(
  parameter logic [4:0]  CMD_IDLE          = 5'd0,
  parameter logic [4:0]  CMD_START         = 5'd1,
  parameter logic [4:0]  CMD_DATA_TRANSFER = 5'd2,
  parameter logic [4:0]  CMD_RESTART       = 5'd3,
  parameter logic [4:0]  CMD_STOP          = 5'd4,
  parameter logic [11:0] TIMEOUT_CYCLES    = 12'd4095
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_reg,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_len,
  input  logic       i_t_HD_STA_done,
  input  logic       i_byte_done,
  input  logic       i_ack_bit,
  input  logic [7:0] i_rx_byte,
  input  logic       i_stop_done,
  output logic [4:0] o_cmd_state,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_load,
  output logic       o_master_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_timeout,
  output logic [7:0] o_rdata,
  output logic       o_rdata_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
    S_RESTART, S_ADDR_R, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t      state;
  logic        rw_q;
  logic [6:0]  addr_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [3:0]  len_q;
  logic [3:0]  cnt;
  logic [11:0] wd;

  logic [3:0] len_eff;
  logic       last_byte;
  logic       wd_expired;

  always_comb begin
    len_eff    = (len_q == 4'd0) ? 4'd1 : len_q;
    last_byte  = (cnt == len_eff - 4'd1);
    // Expiry on the TIMEOUT_CYCLES-th clock spent in the current state
    wd_expired = (wd == TIMEOUT_CYCLES - 12'd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      len_q         <= '0;
      cnt           <= '0;
      wd            <= '0;
      o_cmd_state   <= CMD_IDLE;
      o_tx_byte     <= '0;
      o_tx_load     <= 1'b0;
      o_master_ack  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_nack        <= 1'b0;
      o_timeout     <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
    end else begin
      o_tx_load     <= 1'b0;
      o_done        <= 1'b0;
      o_rdata_valid <= 1'b0;
      wd            <= wd + 12'd1;
      case (state)
        S_IDLE: begin
          wd <= '0;
          if (i_start) begin
            rw_q        <= i_rw;
            addr_q      <= i_addr;
            reg_q       <= i_reg;
            wdata_q     <= i_wdata;
            len_q       <= i_len;
            o_nack      <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b1;
            state       <= S_START;
            o_cmd_state <= CMD_START;
          end
        end
        S_START, S_RESTART: begin
          if (i_t_HD_STA_done) begin
            state       <= (state == S_START) ? S_ADDR_W : S_ADDR_R;
            o_cmd_state <= CMD_DATA_TRANSFER;
            o_tx_byte   <= {addr_q, (state == S_RESTART)};
            o_tx_load   <= 1'b1;
            wd          <= '0;
          end else if (wd_expired) begin
            o_timeout   <= 1'b1;
            state       <= S_STOP;
            o_cmd_state <= CMD_STOP;
            wd          <= '0;
          end
        end
        S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
          if (i_byte_done) begin
            wd <= '0;
            if (i_ack_bit) begin
              o_nack      <= 1'b1;
              state       <= S_STOP;
              o_cmd_state <= CMD_STOP;
            end else begin
              case (state)
                S_ADDR_W: begin
                  state     <= S_REG;
                  o_tx_byte <= reg_q;
                  o_tx_load <= 1'b1;
                end
                S_REG: begin
                  if (rw_q) begin
                    state       <= S_RESTART;
                    o_cmd_state <= CMD_RESTART;
                  end else if (len_q == 4'd0) begin
                    state       <= S_STOP;
                    o_cmd_state <= CMD_STOP;
                  end else begin
                    state     <= S_WDATA;
                    cnt       <= '0;
                    o_tx_byte <= wdata_q;
                    o_tx_load <= 1'b1;
                  end
                end
                S_WDATA: begin
                  if (last_byte) begin
                    state       <= S_STOP;
                    o_cmd_state <= CMD_STOP;
                  end else begin
                    cnt       <= cnt + 4'd1;
                    o_tx_load <= 1'b1;
                  end
                end
                default: begin
                  state        <= S_RDATA;
                  cnt          <= '0;
                  o_master_ack <= (len_eff == 4'd1);
                end
              endcase
            end
          end else if (wd_expired) begin
            o_timeout   <= 1'b1;
            state       <= S_STOP;
            o_cmd_state <= CMD_STOP;
            wd          <= '0;
          end
        end
        S_RDATA: begin
          if (i_byte_done) begin
            wd            <= '0;
            o_rdata       <= i_rx_byte;
            o_rdata_valid <= 1'b1;
            if (last_byte) begin
              o_master_ack <= 1'b0;
              state        <= S_STOP;
              o_cmd_state  <= CMD_STOP;
            end else begin
              // NACK level for the following byte is decided here, before it starts
              cnt          <= cnt + 4'd1;
              o_master_ack <= (cnt + 4'd1 == len_eff - 4'd1);
            end
          end else if (wd_expired) begin
            o_master_ack <= 1'b0;
            o_timeout    <= 1'b1;
            state        <= S_STOP;
            o_cmd_state  <= CMD_STOP;
            wd           <= '0;
          end
        end
        S_STOP: begin
          if (i_stop_done || wd_expired) begin
            if (!i_stop_done) o_timeout <= 1'b1;
            state       <= S_DONE;
            o_cmd_state <= CMD_IDLE;
            o_done      <= 1'b1;
            wd          <= '0;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          wd     <= '0;
        end
        default: begin
          state       <= S_IDLE;
          o_cmd_state <= CMD_IDLE;
          o_busy      <= 1'b0;
          wd          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed bench for i2c_transaction_sequencer: write, read, NACK, timeout,
// ignored mid-transaction start with pointer-only write, and async reset.
module tb_i2c_transaction_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start = 1'b0;
  logic       i_rw = 1'b0;
  logic [6:0] i_addr = '0;
  logic [7:0] i_reg = '0;
  logic [7:0] i_wdata = '0;
  logic [3:0] i_len = '0;
  logic       i_t_HD_STA_done = 1'b0;
  logic       i_byte_done = 1'b0;
  logic       i_ack_bit = 1'b0;
  logic [7:0] i_rx_byte = '0;
  logic       i_stop_done = 1'b0;
  logic [4:0] o_cmd_state;
  logic [7:0] o_tx_byte;
  logic       o_tx_load;
  logic       o_master_ack;
  logic       o_busy;
  logic       o_done;
  logic       o_nack;
  logic       o_timeout;
  logic [7:0] o_rdata;
  logic       o_rdata_valid;

  i2c_transaction_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rw(i_rw),
    .i_addr(i_addr), .i_reg(i_reg), .i_wdata(i_wdata), .i_len(i_len),
    .i_t_HD_STA_done(i_t_HD_STA_done), .i_byte_done(i_byte_done),
    .i_ack_bit(i_ack_bit), .i_rx_byte(i_rx_byte), .i_stop_done(i_stop_done),
    .o_cmd_state(o_cmd_state), .o_tx_byte(o_tx_byte), .o_tx_load(o_tx_load),
    .o_master_ack(o_master_ack), .o_busy(o_busy), .o_done(o_done),
    .o_nack(o_nack), .o_timeout(o_timeout), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid)
  );

  always #50 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Event history, newest entry in the low bits
  logic [63:0] tx_acc = '0;
  logic [63:0] cmd_acc = '0;
  logic [63:0] rd_acc = '0;
  logic [4:0]  last_cmd = 5'd0;
  int tx_n = 0, rd_n = 0, done_n = 0;

  always @(negedge i_clk) begin
    if (o_tx_load === 1'b1) begin
      tx_acc = {tx_acc[55:0], o_tx_byte};
      tx_n++;
    end
    if (o_cmd_state !== last_cmd) begin
      cmd_acc  = {cmd_acc[55:0], 3'b000, o_cmd_state};
      last_cmd = o_cmd_state;
    end
    if (o_rdata_valid === 1'b1) begin
      rd_acc = {rd_acc[55:0], o_rdata};
      rd_n++;
    end
    if (o_done === 1'b1) done_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_txn(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [3:0] len);
    i_rw = rw; i_addr = addr; i_reg = rg; i_wdata = wd; i_len = len;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
  endtask

  task automatic hd_pulse;
    i_t_HD_STA_done = 1'b1;
    tick;
    i_t_HD_STA_done = 1'b0;
  endtask

  task automatic bd_pulse(input logic ack, input logic [7:0] rx);
    i_byte_done = 1'b1; i_ack_bit = ack; i_rx_byte = rx;
    tick;
    i_byte_done = 1'b0; i_ack_bit = 1'b0;
  endtask

  task automatic stop_pulse;
    i_stop_done = 1'b1;
    tick;
    i_stop_done = 1'b0;
  endtask

  int tx0, rd0, done0, n;

  initial begin
    i_rst = 1'b1;
    repeat (3) tick;
    check("reset_cmd", 64'(o_cmd_state), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_outs", 64'({o_tx_load, o_done, o_nack, o_timeout, o_rdata_valid, o_master_ack}), 64'd0);
    i_rst = 1'b0;
    tick;

    // Register write, two data bytes
    tx0 = tx_n; done0 = done_n;
    start_txn(1'b0, 7'h3C, 8'h10, 8'hA5, 4'd2);
    check("wr_busy", 64'(o_busy), 64'd1);
    check("wr_cmd_start", 64'(o_cmd_state), 64'd1);
    tick; tick;
    hd_pulse;
    check("wr_addr_byte", 64'(o_tx_byte), 64'h78);
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    check("wr_cmd_after_data", 64'(o_cmd_state), 64'd2);
    bd_pulse(1'b0, 8'h00);
    check("wr_cmd_stop", 64'(o_cmd_state), 64'd4);
    stop_pulse;
    check("wr_done", 64'(o_done), 64'd1);
    tick;
    check("wr_idle", 64'({o_busy, o_done}), 64'd0);
    check("wr_tx_seq", tx_acc[31:0], 64'h7810A5A5);
    check("wr_loads", 64'(tx_n - tx0), 64'd4);
    check("wr_cmd_seq", cmd_acc[31:0], 64'h01020400);
    check("wr_done_cnt", 64'(done_n - done0), 64'd1);
    check("wr_nack", 64'(o_nack), 64'd0);

    // Register read, three bytes
    tx0 = tx_n; rd0 = rd_n;
    start_txn(1'b1, 7'h50, 8'h02, 8'h00, 4'd3);
    hd_pulse;
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    check("rd_cmd_restart", 64'(o_cmd_state), 64'd3);
    hd_pulse;
    bd_pulse(1'b0, 8'h00);
    check("rd_ack0", 64'(o_master_ack), 64'd0);
    bd_pulse(1'b1, 8'h11);
    check("rd_byte0", 64'({o_rdata_valid, o_rdata}), 64'h111);
    check("rd_ack1", 64'(o_master_ack), 64'd0);
    bd_pulse(1'b0, 8'h22);
    check("rd_ack2", 64'(o_master_ack), 64'd1);
    bd_pulse(1'b0, 8'h33);
    check("rd_byte2", 64'({o_rdata_valid, o_rdata}), 64'h133);
    check("rd_cmd_stop", 64'(o_cmd_state), 64'd4);
    stop_pulse;
    tick;
    check("rd_tx_seq", tx_acc[23:0], 64'hA002A1);
    check("rd_loads", 64'(tx_n - tx0), 64'd3);
    check("rd_cmd_seq", cmd_acc[47:0], 64'h010203020400);
    check("rd_data_seq", rd_acc[23:0], 64'h112233);
    check("rd_valid_cnt", 64'(rd_n - rd0), 64'd3);

    // Address NACK
    tx0 = tx_n;
    start_txn(1'b0, 7'h3C, 8'h10, 8'hA5, 4'd2);
    hd_pulse;
    bd_pulse(1'b1, 8'h00);
    check("nack_cmd_stop", 64'(o_cmd_state), 64'd4);
    check("nack_flag", 64'(o_nack), 64'd1);
    tick;
    check("nack_loads", 64'(tx_n - tx0), 64'd1);
    stop_pulse;
    check("nack_done", 64'(o_done), 64'd1);
    tick;
    check("nack_sticky", 64'({o_nack, o_busy}), 64'h2);
    start_txn(1'b0, 7'h3C, 8'h10, 8'hA5, 4'd2);
    check("nack_cleared", 64'(o_nack), 64'd0);

    // Watchdog expiry in START (continues from the transaction just started)
    n = 0;
    while (o_cmd_state === 5'd1 && n < 5000) begin
      tick;
      n++;
    end
    check("to_start_cycles", 64'(n), 64'd4095);
    check("to_flag_cmd", 64'({o_timeout, o_cmd_state}), 64'h24);
    stop_pulse;
    check("to_done", 64'({o_done, o_timeout}), 64'h3);
    tick;

    // Mid-transaction start ignored, pointer-only write
    tx0 = tx_n;
    start_txn(1'b0, 7'h3C, 8'h55, 8'h99, 4'd0);
    i_addr = 7'h11; i_len = 4'd5; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    hd_pulse;
    check("mid_addr_byte", 64'(o_tx_byte), 64'h78);
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    check("len0_cmd_stop", 64'(o_cmd_state), 64'd4);
    stop_pulse;
    tick;
    check("len0_loads", 64'(tx_n - tx0), 64'd2);
    check("len0_tx_seq", tx_acc[15:0], 64'h7855);
    check("len0_cmd_seq", cmd_acc[31:0], 64'h01020400);

    // Asynchronous reset during RDATA
    start_txn(1'b1, 7'h50, 8'h02, 8'h00, 4'd2);
    hd_pulse;
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    hd_pulse;
    bd_pulse(1'b0, 8'h00);
    check("rst_pre_cmd", 64'(o_cmd_state), 64'd2);
    #20 i_rst = 1'b1;
    #1;
    check("rst_async", 64'({o_cmd_state, o_busy}), 64'd0);
    #10 i_rst = 1'b0;
    tick;
    tx0 = tx_n; done0 = done_n;
    start_txn(1'b0, 7'h2A, 8'h33, 8'h44, 4'd1);
    hd_pulse;
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    bd_pulse(1'b0, 8'h00);
    stop_pulse;
    tick;
    check("post_rst_tx_seq", tx_acc[23:0], 64'h543344);
    check("post_rst_loads", 64'(tx_n - tx0), 64'd3);
    check("post_rst_done", 64'(done_n - done0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
